// File: rtl/fire_pkg.sv
// rtl/fire_pkg.sv - shared state encoding and 100 MHz timing defaults for fire_conditioner
package fire_pkg;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] ST_HELD         = 3'd2;
    localparam logic [2:0] ST_RELEASE_WAIT = 3'd3;
    localparam logic [2:0] ST_STUCK        = 3'd4;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_STUCK_CYCLES    = 500_000_000;
    localparam int DEF_AUTOFIRE_PERIOD = 10_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fire_conditioner_sync_ff.sv
// rtl/fire_conditioner_sync_ff.sv - sync_ff: STAGES-deep flop chain, async reset to 0
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fire_conditioner.sv
// rtl/fire_conditioner.sv - debounced fire pulse, held flag and stuck-button error
// Optional macro FIRE_CONDITIONER_AUTOFIRE_EN adds repeat pulses while the button stays held.
module fire_conditioner
    import fire_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES,
    parameter int AUTOFIRE_PERIOD = DEF_AUTOFIRE_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic enable,
    output logic fire,
    output logic held,
    output logic error
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, STUCK_CYCLES, AUTOFIRE_PERIOD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEB_LAST   = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t STUCK_LAST = cnt_t'(STUCK_CYCLES - 1);

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic       btn_s;
    logic [2:0] state, state_nx;
    cnt_t       deb_cnt, deb_nx;
    cnt_t       hold_cnt, hold_nx;
    logic       fire_nx;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_btn_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn_raw),
        .q    (btn_s)
    );

`ifdef FIRE_CONDITIONER_AUTOFIRE_EN
    localparam cnt_t AF_LAST = cnt_t'(AUTOFIRE_PERIOD - 1);
    cnt_t af_cnt, af_nx;
`endif

    always_comb begin
        state_nx = state;
        deb_nx   = deb_cnt;
        hold_nx  = hold_cnt;
        fire_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (btn_s) begin
                    state_nx = ST_PRESS_WAIT;
                    deb_nx   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nx = ST_IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx = ST_HELD;
                    hold_nx  = '0;
                    fire_nx  = enable;
                end else begin
                    deb_nx = sat_inc(deb_cnt);
                end
            end
            ST_HELD: begin
                hold_nx = sat_inc(hold_cnt);
                // Stuck detection wins over a simultaneous release.
                if (hold_cnt == STUCK_LAST) begin
                    state_nx = ST_STUCK;
                    deb_nx   = '0;
                end else if (!btn_s) begin
                    state_nx = ST_RELEASE_WAIT;
                    deb_nx   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                hold_nx = sat_inc(hold_cnt);
                if (btn_s) begin
                    state_nx = ST_HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx = ST_IDLE;
                end else begin
                    deb_nx = sat_inc(deb_cnt);
                end
            end
            ST_STUCK: begin
                if (btn_s) begin
                    deb_nx = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx = ST_IDLE;
                end else begin
                    deb_nx = sat_inc(deb_cnt);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

`ifdef FIRE_CONDITIONER_AUTOFIRE_EN
    // Repeat pulses only while the button is still down and staying in HELD.
    always_comb begin
        af_nx = af_cnt;
        if (state == ST_PRESS_WAIT && state_nx == ST_HELD) begin
            af_nx = '0;
        end else if (state == ST_HELD) begin
            if (af_cnt == AF_LAST) begin
                af_nx = '0;
            end else begin
                af_nx = sat_inc(af_cnt);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            af_cnt <= '0;
        end else begin
            af_cnt <= af_nx;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            deb_cnt  <= '0;
            hold_cnt <= '0;
            fire     <= 1'b0;
            held     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nx;
            deb_cnt  <= deb_nx;
            hold_cnt <= hold_nx;
`ifdef FIRE_CONDITIONER_AUTOFIRE_EN
            fire     <= fire_nx
                      | (state == ST_HELD && af_cnt == AF_LAST && state_nx == ST_HELD && enable);
`else
            fire     <= fire_nx;
`endif
            held     <= (state_nx == ST_HELD) || (state_nx == ST_RELEASE_WAIT);
            error    <= (state_nx == ST_STUCK);
        end
    end

endmodule

// File: tb/tb_fire_conditioner.sv
// tb/tb_fire_conditioner.sv - scoreboard bench for fire_conditioner
module tb_fire_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic enable;
    logic fire;
    logic held;
    logic error;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int base;
    int exp_cyc;
    int exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fire_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .STUCK_CYCLES   (32),
        .AUTOFIRE_PERIOD(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .enable (enable),
        .fire   (fire),
        .held   (held),
        .error  (error)
    );

    // Fire monitor: every pulse must match the oldest expected edge number.
    always @(negedge clk) begin
        if (fire === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fire: fire=1 at edge %0d, none expected", cyc);
            end else begin
                exp_cyc = exp_q.pop_front();
                if (exp_cyc != cyc) begin
                    errors++;
                    $display("FAIL fire_edge: fire at edge %0d, expected edge %0d", cyc, exp_cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at edge %0d", name, act, exp, cyc);
        end
    endtask

    // Press accepted at edge b+7; with autofire, repeats every 8 edges after that.
    task automatic expect_press(input int b, input int n_af);
        exp_q.push_back(b + 7);
`ifdef FIRE_CONDITIONER_AUTOFIRE_EN
        for (int k = 1; k <= n_af; k++) exp_q.push_back(b + 7 + 8 * k);
`else
        if (n_af < 0) exp_q.push_back(b);
`endif
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d fire pulse(s) missing, first expected at edge %0d",
                     name, exp_q.size(), exp_q[0]);
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: bench did not complete, edge %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        reset   = 1'b1;
        btn_raw = 1'b0;
        enable  = 1'b0;
        tick(3);
        check("reset_fire", fire, 1'b0);
        check("reset_held", held, 1'b0);
        check("reset_error", error, 1'b0);
        reset = 1'b0;
        tick(2);
        check("idle_held", held, 1'b0);

        // 1. clean press, held 20 cycles
        enable  = 1'b1;
        base    = cyc;
        btn_raw = 1'b1;
        expect_press(base, 1);
        tick(6);
        check("t1_held_early", held, 1'b0);
        tick(1);
        check("t1_held_rise", held, 1'b1);
        tick(13);
        btn_raw = 1'b0;
        tick(6);
        check("t1_held_before_fall", held, 1'b1);
        tick(1);
        check("t1_held_fall", held, 1'b0);
        check("t1_error", error, 1'b0);
        drain("t1_pulses");
        tick(5);

        // 2. bounce every 2 cycles
        for (int i = 0; i < 16; i++) begin
            btn_raw = ((i / 2) % 2 == 0);
            tick(1);
            check("t2_bounce_held", held, 1'b0);
        end
        btn_raw = 1'b0;
        tick(10);
        check("t2_held", held, 1'b0);
        check("t2_error", error, 1'b0);

        // 3. enable gating
        enable  = 1'b0;
        btn_raw = 1'b1;
        tick(7);
        check("t3_held_no_enable", held, 1'b1);
        tick(5);
        enable = 1'b1;
        tick(8);
        check("t3_still_held", held, 1'b1);
        btn_raw = 1'b0;
        tick(10);
        check("t3_released", held, 1'b0);
        base    = cyc;
        btn_raw = 1'b1;
        expect_press(base, 1);
        tick(7);
        check("t3_second_held", held, 1'b1);
        tick(8);
        btn_raw = 1'b0;
        tick(10);
        drain("t3_pulses");

        // 4. stuck button
        base    = cyc;
        btn_raw = 1'b1;
        expect_press(base, 3);
        tick(38);
        check("t4_error_before", error, 1'b0);
        check("t4_held_before", held, 1'b1);
        tick(1);
        check("t4_error_set", error, 1'b1);
        check("t4_held_stuck", held, 1'b0);
        tick(11);
        btn_raw = 1'b0;
        tick(5);
        check("t4_error_hold", error, 1'b1);
        tick(1);
        check("t4_error_clear", error, 1'b0);
        drain("t4_pulses");
        tick(5);
        base    = cyc;
        btn_raw = 1'b1;
        expect_press(base, 0);
        tick(10);
        btn_raw = 1'b0;
        tick(10);
        drain("t4_repress");

        // 5. reset mid-press, then again while held
        btn_raw = 1'b1;
        tick(5);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_fire", fire, 1'b0);
        check("t5_rst_held", held, 1'b0);
        tick(2);
        reset = 1'b0;
        base  = cyc;
        expect_press(base, 0);
        tick(6);
        check("t5_held_early", held, 1'b0);
        tick(1);
        check("t5_held_rise", held, 1'b1);
        tick(3);
        #2 reset = 1'b1;
        #1;
        check("t5_async_held", held, 1'b0);
        tick(2);
        btn_raw = 1'b0;
        reset   = 1'b0;
        tick(10);
        drain("t5_pulses");

        // 6. hold 30 cycles
        base    = cyc;
        btn_raw = 1'b1;
        expect_press(base, 3);
        tick(30);
        btn_raw = 1'b0;
        tick(12);
        check("t6_held_end", held, 1'b0);
        drain("t6_pulses");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
